// File: rtl/pcie_tl_pkg.sv
// Shared types and constants for the PCIe transaction-layer TX arbiter.
package pcie_tl_pkg;

  localparam int unsigned TLP_HDR_W  = 128;
  localparam int unsigned TLP_DATA_W = 256;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // One requester beat as seen on a slice of the request bus
  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [TLP_HDR_W-1:0]  header;
    logic [TLP_DATA_W-1:0] data;
  } tlp_beat_t;

endpackage

// File: rtl/pcie_tl_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module pcie_tl_rr_pick
  import pcie_tl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic               found,
  output logic [IW-1:0]      idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      if (!found && req[IW'((int'(last_grant) + i) % int'(NUM_REQ))]) begin
        found = 1'b1;
        idx   = IW'((int'(last_grant) + i) % int'(NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/pcie_tl_tx_arbiter.sv
// Packet-granular round-robin arbiter onto the DLL TX path.
// Optional credit gating when PCIE_TL_ARB_FC_EN is defined.
module pcie_tl_tx_arbiter
  import pcie_tl_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 3,
  parameter int unsigned DATA_WIDTH       = 256,
  parameter int unsigned TLP_HEADER_WIDTH = 128,
  parameter int unsigned CREDIT_WIDTH     = 8,
  parameter int unsigned INIT_CREDITS     = 16,
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_sop,
  input  logic [NUM_REQ-1:0]                    req_eop,
  input  logic [NUM_REQ*TLP_HEADER_WIDTH-1:0]   req_header,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  tx_valid,
  output logic                                  tx_sop,
  output logic                                  tx_eop,
  output logic [TLP_HEADER_WIDTH-1:0]           tx_header,
  output logic [DATA_WIDTH-1:0]                 tx_data,
  input  logic                                  tx_ready,
  input  logic                                  fc_update,
  input  logic [CREDIT_WIDTH-1:0]               fc_credits,
  output logic [IW-1:0]                         grant_id,
  output logic                                  busy,
  output logic                                  err_no_sop
);

  localparam logic [0:0] ST_IDLE = 1'(ARB_IDLE);
  localparam logic [0:0] ST_XFER = 1'(ARB_XFER);

  logic [0:0]         state, state_n;
  logic [IW-1:0]      last_grant, last_n, grant_n;
  logic               grant_take;
  logic               credit_ok;
  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] cand;
  logic               no_sop_seen;

  assign cand        = req_valid & req_sop & {NUM_REQ{credit_ok}};
  assign no_sop_seen = (state == ST_IDLE) && (|(req_valid & ~req_sop));

  pcie_tl_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (cand),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

`ifdef PCIE_TL_ARB_FC_EN
  localparam logic [CREDIT_WIDTH:0] CRED_MAX = {1'b0, {CREDIT_WIDTH{1'b1}}};
  logic [CREDIT_WIDTH-1:0] credit_cnt;
  logic [CREDIT_WIDTH:0]   credit_sum;

  assign credit_ok = (credit_cnt != '0);

  // Return and consume in the same cycle, saturating at the counter maximum
  always_comb begin
    credit_sum = {1'b0, credit_cnt};
    if (fc_update)  credit_sum = credit_sum + {1'b0, fc_credits};
    if (grant_take) credit_sum = credit_sum - (CREDIT_WIDTH+1)'(1);
    if (credit_sum > CRED_MAX) credit_sum = CRED_MAX;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) credit_cnt <= CREDIT_WIDTH'(INIT_CREDITS);
    else        credit_cnt <= credit_sum[CREDIT_WIDTH-1:0];
  end
`else
  logic unused_fc;
  assign credit_ok = 1'b1;
  assign unused_fc = ^{fc_update, fc_credits, CREDIT_WIDTH'(INIT_CREDITS)};
`endif

  // Next-state: grant whole packets, release on the EOP transfer
  always_comb begin
    state_n    = state;
    grant_n    = grant_id;
    last_n     = last_grant;
    grant_take = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_n    = ST_XFER;
          grant_n    = pick_idx;
          grant_take = 1'b1;
        end
      end
      ST_XFER: begin
        if (req_valid[grant_id] && tx_ready && req_eop[grant_id]) begin
          state_n = ST_IDLE;
          last_n  = grant_id;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Data path is a pure mux of the granted slice
  always_comb begin
    tx_valid  = 1'b0;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    req_ready = '0;
    tx_header = req_header[int'(grant_id)*TLP_HEADER_WIDTH +: TLP_HEADER_WIDTH];
    tx_data   = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    if (state == ST_XFER) begin
      tx_valid            = req_valid[grant_id];
      tx_sop              = req_sop[grant_id];
      tx_eop              = req_eop[grant_id];
      req_ready[grant_id] = tx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant_id   <= '0;
      busy       <= 1'b0;
      err_no_sop <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_n;
      grant_id   <= grant_n;
      busy       <= (state_n == ST_XFER);
      if (no_sop_seen) err_no_sop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcie_tl_tx_arbiter.sv
// Directed self-checking bench for pcie_tl_tx_arbiter.
module tb_pcie_tl_tx_arbiter;

  localparam int NR = 3;
  localparam int HW = 128;
  localparam int DW = 256;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_sop, req_eop, req_ready;
  logic [NR*HW-1:0]  req_header;
  logic [NR*DW-1:0]  req_data;
  logic              tx_valid, tx_sop, tx_eop, tx_ready;
  logic [HW-1:0]     tx_header;
  logic [DW-1:0]     tx_data;
  logic              fc_update;
  logic [CW-1:0]     fc_credits;
  logic [1:0]        grant_id;
  logic              busy, err_no_sop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pcie_tl_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .TLP_HEADER_WIDTH(HW),
    .CREDIT_WIDTH(CW), .INIT_CREDITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop),
    .req_header(req_header), .req_data(req_data), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_header(tx_header), .tx_data(tx_data), .tx_ready(tx_ready),
    .fc_update(fc_update), .fc_credits(fc_credits),
    .grant_id(grant_id), .busy(busy), .err_no_sop(err_no_sop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic s, input logic e,
                         input logic [HW-1:0] h, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_sop[i]   = s;
    req_eop[i]   = e;
    req_header[i*HW +: HW] = h;
    req_data[i*DW +: DW]   = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_sop = '0; req_eop = '0;
    req_header = '0; req_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    tx_ready = 1'b0; fc_update = 1'b0; fc_credits = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    tx_ready = 1'b1; fc_update = 1'b0; fc_credits = '0;
    tick(); tick();
    total += 6;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    if (tx_sop !== 1'b0 || tx_eop !== 1'b0) begin bad++; $display("FAIL reset_sop_eop got=%b%b exp=00", tx_sop, tx_eop); end
    if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_req_ready got=%b exp=000", req_ready); end
    if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (err_no_sop !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_no_sop); end
    rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_beat();
    do_reset();
    tx_ready = 1'b1;
    set_req(1, 1'b1, 1'b1, 1'b1, 128'hA5, 256'h1234);
    #1;
    total += 2;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b exp=0", tx_valid); end
    if (req_ready !== 3'b000) begin bad++; $display("FAIL single_idle_ready got=%b exp=000", req_ready); end
    tick();
    total += 7;
    if (tx_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", tx_valid); end
    if (tx_header !== 128'hA5) begin bad++; $display("FAIL single_header got=%h exp=a5", tx_header); end
    if (tx_data !== 256'h1234) begin bad++; $display("FAIL single_data got=%h exp=1234", tx_data); end
    if (grant_id !== 2'd1) begin bad++; $display("FAIL single_grant got=%0d exp=1", grant_id); end
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    if (req_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    if (tx_sop !== 1'b1 || tx_eop !== 1'b1) begin bad++; $display("FAIL single_sop_eop got=%b%b exp=11", tx_sop, tx_eop); end
    tick();
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_done_busy got=%b exp=0", busy); end
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_done_valid got=%b exp=0", tx_valid); end
    if (grant_id !== 2'd1) begin bad++; $display("FAIL single_done_grant got=%0d exp=1", grant_id); end
  endtask

  task automatic test_round_robin();
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 1'b1, 128'(32'h10 + i), 256'(i));
    for (int k = 0; k < 6; k++) begin
      tick();
      total += 3;
      if (grant_id !== 2'(k % 3)) begin bad++; $display("FAIL rr_grant k=%0d got=%0d exp=%0d", k, grant_id, k % 3); end
      if (busy !== 1'b1) begin bad++; $display("FAIL rr_busy k=%0d got=%b exp=1", k, busy); end
      if (tx_header !== 128'(32'h10 + (k % 3))) begin bad++; $display("FAIL rr_header k=%0d got=%h exp=%h", k, tx_header, 32'h10 + (k % 3)); end
      tick();
      total += 2;
      if (busy !== 1'b0) begin bad++; $display("FAIL rr_bubble_busy k=%0d got=%b exp=0", k, busy); end
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL rr_bubble_valid k=%0d got=%b exp=0", k, tx_valid); end
    end
    clear_reqs();
  endtask

  task automatic test_hold_packet();
    int beat;
    do_reset();
    beat = 0;
    tx_ready = 1'b1;
    set_req(0, 1'b1, 1'b1, 1'b0, 128'hB0, '0);
    set_req(2, 1'b1, 1'b1, 1'b1, 128'hC2, '0);
    tick();
    total++;
    if (grant_id !== 2'd0) begin bad++; $display("FAIL hold_grant0 got=%0d exp=0", grant_id); end
    for (int c = 0; c < 7; c++) begin
      tx_ready = (c % 2 == 0);
      set_req(0, 1'b1, beat == 0, beat == 3, 128'(32'hB0 + beat), '0);
      #1;
      total += 4;
      if (tx_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c=%0d got=%b exp=1", c, tx_valid); end
      if (tx_header !== 128'(32'hB0 + beat)) begin bad++; $display("FAIL hold_header c=%0d got=%h exp=%h", c, tx_header, 32'hB0 + beat); end
      if (req_ready !== {2'b00, tx_ready}) begin bad++; $display("FAIL hold_ready c=%0d got=%b exp=00%b", c, req_ready, tx_ready); end
      if (tx_eop !== (beat == 3)) begin bad++; $display("FAIL hold_eop c=%0d got=%b exp=%b", c, tx_eop, beat == 3); end
      tick();
      if (tx_ready) beat++;
      if (beat == 4) set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    end
    tx_ready = 1'b1;
    #1;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL hold_end_busy got=%b exp=0", busy); end
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL hold_end_valid got=%b exp=0", tx_valid); end
    if (grant_id !== 2'd0) begin bad++; $display("FAIL hold_end_grant got=%0d exp=0", grant_id); end
    tick();
    total += 3;
    if (grant_id !== 2'd2) begin bad++; $display("FAIL hold_next_grant got=%0d exp=2", grant_id); end
    if (tx_header !== 128'hC2) begin bad++; $display("FAIL hold_next_header got=%h exp=c2", tx_header); end
    if (req_ready !== 3'b100) begin bad++; $display("FAIL hold_next_ready got=%b exp=100", req_ready); end
    tick();
    clear_reqs();
  endtask

  task automatic test_no_sop();
    do_reset();
    tx_ready = 1'b1;
    set_req(1, 1'b1, 1'b0, 1'b1, 128'h77, '0);
    #1;
    total += 2;
    if (err_no_sop !== 1'b0) begin bad++; $display("FAIL nosop_early got=%b exp=0", err_no_sop); end
    if (req_ready !== 3'b000) begin bad++; $display("FAIL nosop_ready got=%b exp=000", req_ready); end
    tick();
    clear_reqs();
    total += 2;
    if (err_no_sop !== 1'b1) begin bad++; $display("FAIL nosop_set got=%b exp=1", err_no_sop); end
    if (busy !== 1'b0) begin bad++; $display("FAIL nosop_busy got=%b exp=0", busy); end
    tick();
    total++;
    if (err_no_sop !== 1'b1) begin bad++; $display("FAIL nosop_sticky got=%b exp=1", err_no_sop); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    tx_ready = 1'b1;
    set_req(1, 1'b1, 1'b1, 1'b0, 128'hD0, '0);
    tick();
    total++;
    if (grant_id !== 2'd1) begin bad++; $display("FAIL midrst_grant got=%0d exp=1", grant_id); end
    tick();
    set_req(1, 1'b1, 1'b0, 1'b0, 128'hD1, '0);
    #1;
    total++;
    if (tx_header !== 128'hD1 || busy !== 1'b1) begin bad++; $display("FAIL midrst_beat1 got=%h/%b exp=d1/1", tx_header, busy); end
    rst_n = 1'b0;
    tick();
    total += 3;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", tx_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (grant_id !== 2'd0) begin bad++; $display("FAIL midrst_gid got=%0d exp=0", grant_id); end
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 1'b1, 128'hE0, '0);
    set_req(1, 1'b1, 1'b1, 1'b0, 128'hD0, '0);
    tick();
    total += 2;
    if (grant_id !== 2'd0) begin bad++; $display("FAIL midrst_regrant got=%0d exp=0", grant_id); end
    if (err_no_sop !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", err_no_sop); end
    clear_reqs();
  endtask

  task automatic test_credits();
    do_reset();
    tx_ready = 1'b1;
    set_req(0, 1'b1, 1'b1, 1'b1, 128'hF0, '0);
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL fc_grant k=%0d got=%b exp=1", k, busy); end
      tick();
    end
`ifdef PCIE_TL_ARB_FC_EN
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL fc_stall1 got=%b exp=0", busy); end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL fc_stall2 got=%b exp=0", busy); end
    fc_update = 1'b1;
    fc_credits = 8'd1;
    tick();
    fc_update = 1'b0;
    fc_credits = '0;
    tick();
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL fc_regrant got=%b exp=1", busy); end
    if (grant_id !== 2'd0) begin bad++; $display("FAIL fc_regrant_id got=%0d exp=0", grant_id); end
`else
    tick();
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL nofc_third got=%b exp=1", busy); end
    if (tx_header !== 128'hF0) begin bad++; $display("FAIL nofc_header got=%h exp=f0", tx_header); end
`endif
    clear_reqs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_round_robin();
    test_hold_packet();
    test_no_sop();
    test_mid_reset();
    test_credits();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_tl_tx_arbiter.md
# pcie_tl_tx_arbiter

Round-robin arbiter that shares the Transaction Layer's single TX path to the Data Link Layer between several TLP sources, such as the completion generator, the posted-write requester and the message generator. It sits between those sources and the DLL-facing `tx_*` interface. It grants whole packets from SOP to EOP, never interleaving beats of different requesters. It optionally gates grants on link flow-control credits.

## Interface
- `NUM_REQ`, default 3: number of requesters, range 2..8.
- `DATA_WIDTH`, default 256: data beat width.
- `TLP_HEADER_WIDTH`, default 128: header width.
- `CREDIT_WIDTH`, default 8: credit counter width.
- `INIT_CREDITS`, default 16: credit counter value after reset.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_sop` / `req_eop`  in  NUM_REQ each  per-requester packet delimiters.
- `req_header`  in  NUM_REQ*TLP_HEADER_WIDTH  requester i occupies slice [i*W +: W].
- `req_data`  in  NUM_REQ*DATA_WIDTH  sliced the same way.
- `req_ready`  out  NUM_REQ  beat accepted from requester i.
- `tx_valid`, `tx_sop`, `tx_eop`  out  1 each  to DLL.
- `tx_header`  out  TLP_HEADER_WIDTH  to DLL.
- `tx_data`  out  DATA_WIDTH  to DLL.
- `tx_ready`  in  1  DLL accepts beat.
- `fc_update`  in  1  credit return strobe.
- `fc_credits`  in  CREDIT_WIDTH  credits returned with the strobe.
- `grant_id`  out  $clog2(NUM_REQ)  current or last granted requester.
- `busy`  out  1  high in state XFER.
- `err_no_sop`  out  1  sticky; set when a valid beat without SOP is seen from a non-granted requester in IDLE.

## Operation
- FSM with two states: IDLE and XFER.
- **IDLE**
  - Candidates are requesters with `req_valid & req_sop`, subject to the credit gate.
  - Choose the first candidate in order last_grant+1, +2, … with wrap modulo NUM_REQ.
  - On the next edge, register `grant_id`, consume 1 credit and go to XFER.
  - With no candidate, remain in IDLE.
- **XFER** (granted requester g)
  - Combinational pass-through: `tx_valid=req_valid[g]`, `tx_sop/eop/header/data` come from slice g, `req_ready[g]=tx_ready`.
  - All other `req_ready` bits are 0.
  - A beat transfers when `req_valid[g] & tx_ready`.
  - A transfer with `req_eop[g]` returns to IDLE and sets last_grant=g.
  - A single-beat TLP (SOP and EOP together) occupies XFER for exactly one transfer cycle.
- **In IDLE:** all `req_ready`=0 and `tx_valid`=0. `tx_header`/`tx_data` show slice `grant_id` but are don't-care.
- **Fairness:** a requester waiting with SOP asserted is granted within NUM_REQ-1 intervening packets.
- **Reset values:**
  - state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), `grant_id`=0, `busy`=0, `err_no_sop`=0.
  - All `tx_*` outputs and `req_ready` are 0; credit counter=INIT_CREDITS.
- **Reset mid-packet:** the packet is abandoned and the FSM returns to IDLE. The requester must re-present from SOP.

## Timing
- Grant latency: 1 cycle from SOP presented in IDLE to the first possible `tx_valid`.
- Back-to-back packets incur 1 IDLE bubble cycle between EOP transfer and next SOP.
- `tx_valid` may stay high while `tx_ready`=0. Outputs must then hold stable; this holds because the requester must hold per the valid/ready rule.
- `tx_ready`, `req_valid` and slice data feed `tx_*` and `req_ready` combinationally in XFER. There are no registers in the data path.
- `err_no_sop` is set one cycle after the offending beat and is cleared only by reset.

## Configuration
- `PCIE_TL_ARB_FC_EN` defined:
  - The counter decrements by 1 per grant.
  - `fc_update` adds `fc_credits`, saturating at 2^CREDIT_WIDTH-1.
  - A simultaneous grant and update yields cnt+fc_credits-1, saturated.
  - A grant requires cnt≥1. With cnt=0 the FSM stays in IDLE.
- Not defined:
  - The counter is not instantiated, there is no gating, and `fc_update`/`fc_credits` are ignored.
  - Behaviour is otherwise identical.

## Structure
- Package `pcie_tl_pkg` holds:
  - the FSM state enum `arb_state_e` (IDLE, XFER);
  - the header-width constants;
  - a `tlp_beat_t` struct (sop, eop, header, data) for slicing.
- One sub-module, `pcie_tl_rr_pick`: combinational round-robin priority picker.
  - Inputs: request vector and last_grant.
  - Outputs: found flag and index.

## Test plan
- Reset, then requester 1 alone sends a 1-beat TLP with header 128'hA5 and `tx_ready`=1.
  - Response: `tx_valid` high on cycle 2, `tx_header`=128'hA5, `grant_id`=1, then back to IDLE.
- Requesters 0, 1 and 2 all hold SOP continuously, 1-beat each.
  - Response: grant order 0,1,2,0,1,2 with one bubble between packets.
- Requester 0 sends a 4-beat TLP while requester 2 requests and `tx_ready` toggles 1,0,1.
  - Response: no requester-2 beat appears until requester 0's EOP has transferred; `req_ready[2]`=0 throughout.
- Requester 1 presents valid without SOP in IDLE.
  - Response: no grant, and `err_no_sop`=1 the next cycle.
- With `PCIE_TL_ARB_FC_EN` and INIT_CREDITS=2, send three 1-beat TLPs.
  - Response: the third stalls in IDLE.
  - Then `fc_update`=1 with `fc_credits`=1: the third is granted the next cycle.
- Assert `rst_n`=0 in the middle of a 3-beat packet.
  - Response: the next cycle has `tx_valid`=0, `busy`=0 and state IDLE; the subsequent grant goes to requester 0.
